// File: rtl/axis_arb_pkg.sv
// Shared types, constants and the rotate-priority search used by the AXI-Stream arbiter.
package axis_arb_pkg;

  localparam int STAT_W  = 32;
  localparam int TMO_W   = 16;
  localparam int MAX_SRC = 8;
  localparam int PICK_W  = 3;

  typedef enum logic {IDLE, GRANT} arb_state_e;

  typedef struct packed {
    logic              found;
    logic [PICK_W-1:0] idx;
  } pick_t;

  // First set bit of valid searching ptr+1, ptr+2, ... modulo n (n <= MAX_SRC).
  function automatic pick_t rr_pick(input logic [MAX_SRC-1:0] valid,
                                    input logic [PICK_W-1:0]  ptr,
                                    input int                 n);
    pick_t           r;
    logic [PICK_W:0] cand;
    r = '0;
    for (int k = 1; k <= MAX_SRC; k++) begin
      cand = {1'b0, ptr} + (PICK_W+1)'(k);
      if (cand >= (PICK_W+1)'(n)) cand = cand - (PICK_W+1)'(n);
      if ((k <= n) && !r.found && valid[cand[PICK_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = cand[PICK_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// Combinational rotate-priority encoder: picks the next requesting source after ptr_i.
module axis_rr_pick
  import axis_arb_pkg::*;
#(
  parameter  int NUM_SRC = 2,
  localparam int ID_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] valid_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic               found_o,
  output logic [ID_W-1:0]    sel_o
);

  pick_t pick;

  always_comb begin
    pick    = rr_pick(MAX_SRC'(valid_i), PICK_W'(ptr_i), NUM_SRC);
    found_o = pick.found;
    sel_o   = ID_W'(pick.idx);
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Round-robin arbiter sharing one AXI-Stream sink between NUM_SRC sources in bursts.
// Per-source beat/timeout statistics are built when AXIS_ARB_STATS_EN is defined.
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter  int NUM_SRC      = 2,
  parameter  int DATA_WIDTH   = 32,
  parameter  int BURST_LEN    = 16,
  parameter  int IDLE_TIMEOUT = 4,
  localparam int ID_W         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          arb_en,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]            s_axis_tvalid,
  output logic [NUM_SRC-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [ID_W-1:0]               m_axis_tid,
  output logic                          grant_active
`ifdef AXIS_ARB_STATS_EN
  ,
  output logic [NUM_SRC*STAT_W-1:0]     stat_beats,
  output logic [NUM_SRC*TMO_W-1:0]      stat_timeouts
`endif
);

  localparam int              BC_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int              IC_W      = 8;
  localparam logic [BC_W-1:0] BEAT_LAST = BC_W'(BURST_LEN - 1);
  localparam logic [IC_W-1:0] IDLE_LAST = IC_W'(IDLE_TIMEOUT - 1);

  arb_state_e            state_q, state_d;
  logic [ID_W-1:0]       grant_q, grant_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [BC_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic [IC_W-1:0]       idle_cnt_q, idle_cnt_d;
  logic                  pick_found;
  logic [ID_W-1:0]       pick_sel;
  logic [DATA_WIDTH-1:0] src_data [NUM_SRC];
  logic                  gnt_valid;
  logic                  xfer;
  logic                  timeout_rel;
  logic [NUM_SRC-1:0]    tready_raw;
  logic                  tvalid_raw;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign src_data[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  axis_rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
    .valid_i (s_axis_tvalid),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .sel_o   (pick_sel)
  );

  assign grant_active = (state_q == GRANT);
  assign gnt_valid    = s_axis_tvalid[grant_q];
  assign xfer         = grant_active & gnt_valid & m_axis_tready;
  assign timeout_rel  = grant_active & ~gnt_valid & (idle_cnt_q == IDLE_LAST);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    idle_cnt_d = idle_cnt_q;
    tready_raw = '0;
    tvalid_raw = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_en && pick_found) begin
          grant_d    = pick_sel;
          rr_ptr_d   = pick_sel;
          beat_cnt_d = '0;
          idle_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        tvalid_raw          = gnt_valid;
        tready_raw[grant_q] = m_axis_tready;
        // Backpressure keeps tvalid high, so it never counts toward the timeout.
        idle_cnt_d = gnt_valid ? '0 : idle_cnt_q + 1'b1;
        if (xfer) beat_cnt_d = beat_cnt_q + 1'b1;
        if ((xfer && (beat_cnt_q == BEAT_LAST)) || timeout_rel) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= ID_W'(NUM_SRC - 1);
      beat_cnt_q <= '0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  // Handshakes are masked while reset is held so an aborted burst moves no beat.
  assign s_axis_tready = areset ? '0 : tready_raw;
  assign m_axis_tvalid = tvalid_raw & ~areset;
  assign m_axis_tdata  = src_data[grant_q];
  assign m_axis_tid    = grant_q;

`ifdef AXIS_ARB_STATS_EN
  logic [NUM_SRC-1:0][STAT_W-1:0] beats_q;
  logic [NUM_SRC-1:0][TMO_W-1:0]  timeouts_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      beats_q    <= '0;
      timeouts_q <= '0;
    end else begin
      if (xfer) beats_q[grant_q] <= beats_q[grant_q] + 1'b1;
      if (timeout_rel && (timeouts_q[grant_q] != '1))
        timeouts_q[grant_q] <= timeouts_q[grant_q] + 1'b1;
    end
  end

  assign stat_beats    = beats_q;
  assign stat_timeouts = timeouts_q;
`else
  // Without statistics the arbiter carries no per-source counter state.
`endif

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Self-checking bench for axis_rr_arbiter: first-grant vector table plus scoreboarded bursts.
module tb_axis_rr_arbiter;

  localparam int NS  = 4;
  localparam int DW  = 32;
  localparam int IDW = 2;

  logic            aclk = 1'b0;
  logic            areset;
  logic            arb_en;
  logic [NS*DW-1:0] s_axis_tdata;
  logic [NS-1:0]   s_axis_tvalid;
  logic [NS-1:0]   s_axis_tready;
  logic [DW-1:0]   m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic [IDW-1:0]  m_axis_tid;
  logic            grant_active;
`ifdef AXIS_ARB_STATS_EN
  logic [NS*32-1:0] stat_beats;
  logic [NS*16-1:0] stat_timeouts;
`endif

  always #5 aclk = ~aclk;

  axis_rr_arbiter #(
    .NUM_SRC(NS), .DATA_WIDTH(DW), .BURST_LEN(16), .IDLE_TIMEOUT(4)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .arb_en        (arb_en),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tid    (m_axis_tid),
    .grant_active  (grant_active)
`ifdef AXIS_ARB_STATS_EN
    ,
    .stat_beats    (stat_beats),
    .stat_timeouts (stat_timeouts)
`endif
  );

  typedef struct {
    logic [IDW-1:0] tid;
    logic [DW-1:0]  data;
  } beat_t;

  typedef struct {
    logic [NS-1:0]  valid;
    logic           en;
    logic           exp_act;
    logic [IDW-1:0] exp_tid;
  } vec_t;

  logic [NS-1:0] src_en;
  int unsigned   src_cnt [NS];
  beat_t         exp_q [$];
  vec_t          vecs [8];
  int            checks = 0;
  int            errors = 0;

  function automatic logic [DW-1:0] src_word(input int i, input int unsigned c);
    return (DW'(i) << 16) | (32'h100 + DW'(c));
  endfunction

  assign s_axis_tvalid = src_en;

  always_comb begin
    s_axis_tdata = '0;
    for (int i = 0; i < NS; i++) s_axis_tdata[i*DW +: DW] = src_word(i, src_cnt[i]);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Sample at the falling edge, advance source counters just after the rising edge.
  task automatic cycle();
    beat_t         e;
    logic [NS-1:0] xfer_mask;
    @(negedge aclk);
    xfer_mask = s_axis_tvalid & s_axis_tready;
    if (m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got tid=%0d data=%0h, required no transfer",
                 m_axis_tid, m_axis_tdata);
      end else begin
        e = exp_q.pop_front();
        check("beat_tid", 32'(m_axis_tid), 32'(e.tid));
        check("beat_data", m_axis_tdata, e.data);
      end
    end
    @(posedge aclk);
    #1;
    for (int i = 0; i < NS; i++) if (xfer_mask[i]) src_cnt[i]++;
    #1;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    exp_q.delete();
    cycle();
    cycle();
    areset = 1'b0;
    for (int i = 0; i < NS; i++) src_cnt[i] = 0;
    #1;
  endtask

  task automatic push_burst(input int src, input int unsigned start, input int n);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.tid  = IDW'(src);
      b.data = src_word(src, start + k);
      exp_q.push_back(b);
    end
  endtask

  task automatic run_until_empty(input int budget, output int n);
    n = 0;
    while ((exp_q.size() != 0) && (n < budget)) begin
      cycle();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d beats outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int             n;
    logic           ok;

    vecs[0] = '{valid: 4'b0001, en: 1'b1, exp_act: 1'b1, exp_tid: 2'd0};
    vecs[1] = '{valid: 4'b0010, en: 1'b1, exp_act: 1'b1, exp_tid: 2'd1};
    vecs[2] = '{valid: 4'b0100, en: 1'b1, exp_act: 1'b1, exp_tid: 2'd2};
    vecs[3] = '{valid: 4'b1000, en: 1'b1, exp_act: 1'b1, exp_tid: 2'd3};
    vecs[4] = '{valid: 4'b1100, en: 1'b1, exp_act: 1'b1, exp_tid: 2'd2};
    vecs[5] = '{valid: 4'b1010, en: 1'b1, exp_act: 1'b1, exp_tid: 2'd1};
    vecs[6] = '{valid: 4'b0000, en: 1'b1, exp_act: 1'b0, exp_tid: 2'd0};
    vecs[7] = '{valid: 4'b1111, en: 1'b0, exp_act: 1'b0, exp_tid: 2'd0};

    areset        = 1'b1;
    arb_en        = 1'b0;
    m_axis_tready = 1'b0;
    src_en        = '0;
    for (int i = 0; i < NS; i++) src_cnt[i] = 0;

    // Reset values
    cycle();
    check("rst_tready", 32'(s_axis_tready), 32'd0);
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_tid", 32'(m_axis_tid), 32'd0);
    check("rst_active", 32'(grant_active), 32'd0);

    // First grant after reset for each request pattern
    foreach (vecs[v]) begin
      src_en        = '0;
      m_axis_tready = 1'b0;
      do_reset();
      src_en = vecs[v].valid;
      arb_en = vecs[v].en;
      cycle();
      check($sformatf("vec%0d_active", v), 32'(grant_active), 32'(vecs[v].exp_act));
      check($sformatf("vec%0d_tid", v), 32'(m_axis_tid), 32'(vecs[v].exp_tid));
      check($sformatf("vec%0d_tvalid", v), 32'(m_axis_tvalid), 32'(vecs[v].exp_act));
      check($sformatf("vec%0d_tready", v), 32'(s_axis_tready), 32'd0);
    end

    // All sources requesting: full rotation with one-cycle bubbles
    src_en        = '0;
    arb_en        = 1'b1;
    m_axis_tready = 1'b1;
    do_reset();
    src_en = '1;
    push_burst(0, 0, 16);
    push_burst(1, 0, 16);
    push_burst(2, 0, 16);
    push_burst(3, 0, 16);
    push_burst(0, 16, 16);
    run_until_empty(300, n);
    src_en = '0;
    check("rotate_cycles", n, 85);
`ifdef AXIS_ARB_STATS_EN
    check("rotate_stat_beats0", stat_beats[0 +: 32], 32);
    check("rotate_stat_beats1", stat_beats[32 +: 32], 16);
`endif

    // Single requester: four bursts back to back
    do_reset();
    src_en = 4'b0001;
    push_burst(0, 0, 64);
    run_until_empty(300, n);
    src_en = '0;
    check("single_cycles", n, 68);

    // Idle timeout releases the grant
    do_reset();
    src_en = 4'b0010;
    push_burst(1, 0, 3);
    repeat (4) cycle();
    check("tmo_beats_done", exp_q.size(), 0);
    src_en = 4'b0001;
    repeat (3) cycle();
    check("tmo_still_active", 32'(grant_active), 32'd1);
    check("tmo_still_tid", 32'(m_axis_tid), 32'd1);
    cycle();
    check("tmo_released", 32'(grant_active), 32'd0);
    check("tmo_tid_hold", 32'(m_axis_tid), 32'd1);
    push_burst(0, 0, 16);
    run_until_empty(100, n);
    src_en = '0;
    check("tmo_next_cycles", n, 17);
`ifdef AXIS_ARB_STATS_EN
    check("tmo_stat_timeouts1", stat_timeouts[16 +: 16], 1);
    check("tmo_stat_timeouts0", stat_timeouts[0 +: 16], 0);
    check("tmo_stat_beats1", stat_beats[32 +: 32], 3);
`endif

    // Sink backpressure mid-burst
    do_reset();
    src_en = 4'b0001;
    push_burst(0, 0, 16);
    repeat (6) cycle();
    m_axis_tready = 1'b0;
    ok = 1'b1;
    repeat (20) begin
      cycle();
      if ((m_axis_tdata !== 32'h105) || (m_axis_tvalid !== 1'b1) || (grant_active !== 1'b1))
        ok = 1'b0;
    end
    check("bp_stable", 32'(ok), 32'd1);
    check("bp_data", m_axis_tdata, 32'h105);
    m_axis_tready = 1'b1;
    run_until_empty(100, n);
    check("bp_resume_cycles", n, 11);
    check("bp_bubble", 32'(grant_active), 32'd0);
    src_en = '0;

    // arb_en dropped mid-burst
    do_reset();
    src_en = 4'b0001;
    push_burst(0, 0, 16);
    repeat (6) cycle();
    arb_en = 1'b0;
    run_until_empty(100, n);
    check("en_off_finish_cycles", n, 11);
    ok = 1'b1;
    repeat (10) begin
      cycle();
      if (grant_active !== 1'b0) ok = 1'b0;
    end
    check("en_off_idle_hold", 32'(ok), 32'd1);
    arb_en = 1'b1;
    push_burst(0, 16, 16);
    run_until_empty(100, n);
    src_en = '0;
    check("en_on_cycles", n, 17);

    // Reset mid-burst
    do_reset();
    src_en = '1;
    push_burst(0, 0, 7);
    repeat (8) cycle();
    check("mrst_beats_done", exp_q.size(), 0);
    areset = 1'b1;
    #1;
    check("mrst_cycle_tready", 32'(s_axis_tready), 32'd0);
    check("mrst_cycle_tvalid", 32'(m_axis_tvalid), 32'd0);
    cycle();
    check("mrst_tready", 32'(s_axis_tready), 32'd0);
    check("mrst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("mrst_tid", 32'(m_axis_tid), 32'd0);
    check("mrst_active", 32'(grant_active), 32'd0);
    areset = 1'b0;
    push_burst(0, 7, 16);
    run_until_empty(100, n);
    src_en = '0;
    check("mrst_regrant_cycles", n, 17);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_rr_arbiter.md
Name: axis_rr_arbiter

Overview:
- Round-robin arbiter sharing one AXI-Stream sink (the histogram stage) between NUM_SRC AXI-Stream producers (LFSR generator plus additional sources).
- Grants one source at a time for bursts of up to BURST_LEN beats.
- Releases early if the granted source stalls for IDLE_TIMEOUT cycles.
- Forwards data unmodified and tags each beat with its source index.

Parameters:
- NUM_SRC, 2, number of requesting stream sources (2..8).
- DATA_WIDTH, 32, tdata width per source.
- BURST_LEN, 16, maximum beats per grant (1..256).
- IDLE_TIMEOUT, 4, consecutive cycles of granted tvalid=0 before forced release (1..255).
- ID_W, derived: max(1, clog2(NUM_SRC)).

Ports:
- aclk  in  1  clock, all logic on rising edge.
- areset  in  1  reset, synchronous, active-high.
- arb_en  in  1  when low, no new grant is issued; a grant in progress completes normally.
- s_axis_tdata  in  NUM_SRC*DATA_WIDTH  source data, source i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tvalid  in  NUM_SRC  per-source valid.
- s_axis_tready  out  NUM_SRC  per-source ready.
- m_axis_tdata  out  DATA_WIDTH  muxed data to sink.
- m_axis_tvalid  out  1  sink valid.
- m_axis_tready  in  1  sink ready.
- m_axis_tid  out  ID_W  index of the granted source.
- grant_active  out  1  high while in GRANT state.

Behaviour:
- Clock and reset: single clock aclk; areset is synchronous and active-high.
- Reset values:
  - state=IDLE, grant=0, rr_ptr=NUM_SRC-1 (so the first pick is source 0), beat_cnt=0, idle_cnt=0.
  - Outputs: s_axis_tready all 0, m_axis_tvalid=0, m_axis_tid=0, grant_active=0.
  - Reset mid-burst aborts the burst immediately; no beat is transferred in the reset cycle.
- States:
  - IDLE: if arb_en=1 and any s_axis_tvalid=1, select the first valid source searching rr_ptr+1, rr_ptr+2, ... modulo NUM_SRC. Register grant=sel and rr_ptr=sel; clear beat_cnt and idle_cnt; go to GRANT. Otherwise stay in IDLE.
  - GRANT:
    - m_axis_tvalid = s_axis_tvalid[grant].
    - m_axis_tdata = slice[grant].
    - s_axis_tready[grant] = m_axis_tready; all other tready bits = 0.
    - Data path is combinational from the registered grant, so there is zero added latency per beat.
- Handshake: a beat transfers when m_axis_tvalid & m_axis_tready. beat_cnt increments on each transfer.
- Release from GRANT to IDLE, in either of these cases:
  - Transfer occurs with beat_cnt==BURST_LEN-1.
  - idle_cnt reaches IDLE_TIMEOUT. idle_cnt increments each GRANT cycle with s_axis_tvalid[grant]=0 and clears on any cycle with tvalid=1.
- Sink backpressure (tvalid=1, tready=0) does not advance idle_cnt and never forces release.
- Arbitration bubble: each release costs exactly one IDLE cycle, so back-to-back bursts have a one-cycle gap.
- Simultaneous requests are resolved purely by rotation from rr_ptr; there is no fixed priority.
- Single requester: it is re-granted after the one-cycle bubble.
- arb_en falling during GRANT has no effect until release; the block then stays in IDLE while arb_en=0.
- m_axis_tid holds grant in both states; m_axis_tdata is don't-care in IDLE.
- AXIS rule: the block never deasserts m_axis_tvalid while tready=0 unless the source itself does (pass-through).

Optional Feature:
- Macro: AXIS_ARB_STATS_EN.
- Defined:
  - Adds output stat_beats, width NUM_SRC*32: per-source 32-bit transferred-beat counters, wrapping at 2^32.
  - Adds output stat_timeouts, width NUM_SRC*16: per-source timeout-release counters, saturating at 0xFFFF.
  - Both sets of counters clear on areset.
- Undefined: neither port nor the counter logic exists.

Decomposition:
- Shared package axis_arb_pkg:
  - State enum {IDLE, GRANT}.
  - Function rr_pick(valid, ptr) returning the selected index and a found flag.
  - Constant STAT_W=32.
- One sub-module, axis_rr_pick: combinational rotate-priority encoder, parameterised by NUM_SRC. The FSM, counters and mux stay in the top module.

Test Plan:
- Reset, all tvalid=1, tready=1 → source 0 granted on the cycle after IDLE; 16 beats with tid=0; one-cycle bubble; source 1 granted for 16 beats; then back to 0.
- Source 0 only, data 0x100..0x13F continuous → four 16-beat bursts all with tid=0; 3 bubble cycles in total; data in order, none lost.
- Granted source 1 sends 3 beats then drops tvalid for 4 cycles → release after the 4th idle cycle; source 0 granted next; with stats enabled, stat_timeouts[1]=1.
- Sink tready=0 for 20 cycles mid-burst with source tvalid held → no release; tdata held stable; burst resumes and completes at 16 beats.
- arb_en=0 asserted at beat 5 of a burst → burst completes to 16 beats, then IDLE persists; grant_active=0 until arb_en=1.
- areset asserted at beat 7 → next cycle all outputs at reset values; after release, source 0 is granted first again.
